// File: rtl/temporizador_bcd.sv
// BCD countdown timer, M:SS from 9:59 down to 0:00, one step per prescaled second.
// Feeds the 7-segment decoder directly; exposes a running flag and an end-of-count pulse.
module temporizador_bcd #(
   parameter int TICKS_POR_SEG = 50000000,
   parameter int LARG_PRESC    = 26
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Carregar,
   input  logic [3:0] LoadMin,
   input  logic [3:0] LoadDez,
   input  logic [3:0] LoadSeg,
   input  logic       Iniciar,
   input  logic       Pausar,
   input  logic       Limpar,
   output logic [3:0] Minutos,
   output logic [3:0] DezenaSeg,
   output logic [3:0] Segundos,
   output logic       Contando,
   output logic       Fim
);

   typedef enum logic [1:0] {
      PARADO   = 2'd0,
      CONTANDO = 2'd1,
      PAUSADO  = 2'd2,
      FIM      = 2'd3
   } estado_t;

   localparam logic [LARG_PRESC-1:0] PRESC_MAX = LARG_PRESC'(TICKS_POR_SEG - 1);

   estado_t               estado_q, estado_d;
   logic [3:0]            min_q, min_d;
   logic [3:0]            dez_q, dez_d;
   logic [3:0]            seg_q, seg_d;
   logic [LARG_PRESC-1:0] presc_q, presc_d;
   logic                  contando_q;
   logic                  fim_q, fim_d;

   logic [3:0]            dec_min, dec_dez, dec_seg;
   logic                  dec_zero;
   logic                  digitos_zero;

   function automatic logic [3:0] satura(input logic [3:0] valor, input logic [3:0] maximo);
      return (valor > maximo) ? maximo : valor;
   endfunction

   assign digitos_zero = (min_q == 4'd0) && (dez_q == 4'd0) && (seg_q == 4'd0);

   // One-second decrement with borrow; minutes never underflow, so digits stay valid BCD.
   always_comb begin
      dec_min = min_q;
      dec_dez = dez_q;
      dec_seg = seg_q;
      if (seg_q != 4'd0) begin
         dec_seg = seg_q - 4'd1;
      end else begin
         dec_seg = 4'd9;
         if (dez_q != 4'd0) begin
            dec_dez = dez_q - 4'd1;
         end else begin
            dec_dez = 4'd5;
            dec_min = (min_q != 4'd0) ? (min_q - 4'd1) : 4'd0;
         end
      end
      dec_zero = (dec_min == 4'd0) && (dec_dez == 4'd0) && (dec_seg == 4'd0);
   end

   // NOTE: every signal driven here gets a default first, so no path can leave it
   // unassigned and infer a latch.
   always_comb begin
      estado_d = estado_q;
      min_d    = min_q;
      dez_d    = dez_q;
      seg_d    = seg_q;
      presc_d  = presc_q;
      fim_d    = 1'b0;

      if (Limpar) begin
         estado_d = PARADO;
         min_d    = 4'd0;
         dez_d    = 4'd0;
         seg_d    = 4'd0;
         presc_d  = '0;
      end else if (Carregar && (estado_q != CONTANDO)) begin
         estado_d = PARADO;
         min_d    = satura(LoadMin, 4'd9);
         dez_d    = satura(LoadDez, 4'd5);
         seg_d    = satura(LoadSeg, 4'd9);
         presc_d  = '0;
      end else begin
         case (estado_q)
            PARADO: begin
               if (Iniciar && !digitos_zero) begin
                  estado_d = CONTANDO;
                  presc_d  = '0;
               end
            end
            PAUSADO: begin
               // The prescaler keeps its held value so a partial second resumes.
               if (Iniciar && !digitos_zero) begin
                  estado_d = CONTANDO;
               end
            end
            FIM: begin
               if (Iniciar) begin
                  estado_d = PARADO;
               end
            end
            CONTANDO: begin
               if (Pausar) begin
                  estado_d = PAUSADO;
               end else if (presc_q == PRESC_MAX) begin
                  presc_d = '0;
                  min_d   = dec_min;
                  dez_d   = dec_dez;
                  seg_d   = dec_seg;
                  if (dec_zero) begin
                     estado_d = FIM;
                     fim_d    = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            default: estado_d = PARADO;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         estado_q   <= PARADO;
         min_q      <= 4'd0;
         dez_q      <= 4'd0;
         seg_q      <= 4'd0;
         presc_q    <= '0;
         contando_q <= 1'b0;
         fim_q      <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         min_q      <= min_d;
         dez_q      <= dez_d;
         seg_q      <= seg_d;
         presc_q    <= presc_d;
         contando_q <= (estado_d == CONTANDO);
         fim_q      <= fim_d;
      end
   end

   assign Minutos   = min_q;
   assign DezenaSeg = dez_q;
   assign Segundos  = seg_q;
   assign Contando  = contando_q;
   assign Fim       = fim_q;

endmodule

// File: tb/tb_temporizador_bcd.sv
// Directed bench for temporizador_bcd with a 4-cycle second; expected values hand-computed.
module tb_temporizador_bcd;

   logic       Clock = 1'b0;
   logic       Reset, Carregar, Iniciar, Pausar, Limpar;
   logic [3:0] LoadMin, LoadDez, LoadSeg;
   logic [3:0] Minutos, DezenaSeg, Segundos;
   logic       Contando, Fim;

   int n_vec = 0;
   int n_err = 0;

   temporizador_bcd #(.TICKS_POR_SEG(4), .LARG_PRESC(2)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Carregar  (Carregar),
      .LoadMin   (LoadMin),
      .LoadDez   (LoadDez),
      .LoadSeg   (LoadSeg),
      .Iniciar   (Iniciar),
      .Pausar    (Pausar),
      .Limpar    (Limpar),
      .Minutos   (Minutos),
      .DezenaSeg (DezenaSeg),
      .Segundos  (Segundos),
      .Contando  (Contando),
      .Fim       (Fim)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance n rising edges; inputs change and outputs are sampled 1 time unit after.
   task automatic step(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   function automatic logic [11:0] digitos();
      return {Minutos, DezenaSeg, Segundos};
   endfunction

   task automatic clear_and_load(input logic [3:0] m, input logic [3:0] d, input logic [3:0] s);
      Limpar = 1'b1;
      step(1);
      Limpar   = 1'b0;
      Carregar = 1'b1;
      LoadMin  = m;
      LoadDez  = d;
      LoadSeg  = s;
      step(1);
      Carregar = 1'b0;
   endtask

   task automatic start();
      Iniciar = 1'b1;
      step(1);
      Iniciar = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Carregar = 1'b0; Iniciar = 1'b0; Pausar = 1'b0; Limpar = 1'b0;
      LoadMin = 4'd0; LoadDez = 4'd0; LoadSeg = 4'd0;
      step(2);
      Reset = 1'b0;
      check("reset_digits", digitos(), 12'h000);
      check("reset_contando", Contando, 0);
      check("reset_fim", Fim, 0);

      // Basic load and countdown timing
      clear_and_load(4'd1, 4'd2, 4'd3);
      check("load_123", digitos(), 12'h123);
      check("load_contando", Contando, 0);
      start();
      check("start_contando", Contando, 1);
      step(3);
      check("before_tick", digitos(), 12'h123);
      step(1);
      check("tick1_122", digitos(), 12'h122);
      step(4);
      check("tick2_121", digitos(), 12'h121);

      // Load while counting is ignored
      Carregar = 1'b1; LoadMin = 4'd5; LoadDez = 4'd5; LoadSeg = 4'd5;
      step(1);
      Carregar = 1'b0;
      check("load_ignored", digitos(), 12'h121);
      check("load_ignored_cont", Contando, 1);

      // Borrow chains
      clear_and_load(4'd1, 4'd0, 4'd0);
      start();
      step(4);
      check("borrow_059", digitos(), 12'h059);
      clear_and_load(4'd0, 4'd1, 4'd0);
      start();
      step(4);
      check("borrow_009", digitos(), 12'h009);

      // End of count
      clear_and_load(4'd0, 4'd0, 4'd2);
      start();
      step(7);
      check("end_pre_001", digitos(), 12'h001);
      check("end_pre_fim", Fim, 0);
      step(1);
      check("end_000", digitos(), 12'h000);
      check("end_fim_hi", Fim, 1);
      check("end_contando", Contando, 0);
      step(1);
      check("end_fim_lo", Fim, 0);
      step(5);
      check("end_no_wrap", digitos(), 12'h000);
      check("end_fim_once", Fim, 0);
      Iniciar = 1'b1;
      step(3);
      check("fim_iniciar_cont", Contando, 0);
      check("fim_iniciar_dig", digitos(), 12'h000);
      Iniciar = 1'b0;

      // Pause two cycles into a second, then resume
      clear_and_load(4'd0, 4'd0, 4'd5);
      start();
      step(2);
      Pausar = 1'b1;
      step(1);
      Pausar = 1'b0;
      check("pause_contando", Contando, 0);
      step(20);
      check("pause_hold", digitos(), 12'h005);
      start();
      check("resume_contando", Contando, 1);
      step(1);
      check("resume_pre", digitos(), 12'h005);
      step(1);
      check("resume_tick", digitos(), 12'h004);

      // Saturating load
      clear_and_load(4'd12, 4'd7, 4'd15);
      check("saturate_959", digitos(), 12'h959);

      // Iniciar at 0:00 is ignored
      Limpar = 1'b1;
      step(1);
      Limpar  = 1'b0;
      Iniciar = 1'b1;
      step(2);
      Iniciar = 1'b0;
      check("zero_start_cont", Contando, 0);
      check("zero_start_dig", digitos(), 12'h000);

      // Pausar on the terminal tick wins
      clear_and_load(4'd0, 4'd0, 4'd1);
      start();
      step(3);
      Pausar = 1'b1;
      step(1);
      Pausar = 1'b0;
      check("pause_term_dig", digitos(), 12'h001);
      check("pause_term_fim", Fim, 0);
      check("pause_term_cont", Contando, 0);
      start();
      step(1);
      check("pause_term_end", digitos(), 12'h000);
      check("pause_term_fim2", Fim, 1);

      // Clear and reset mid-count
      clear_and_load(4'd0, 4'd3, 4'd7);
      start();
      step(2);
      Limpar = 1'b1;
      step(1);
      Limpar = 1'b0;
      check("limpar_dig", digitos(), 12'h000);
      check("limpar_cont", Contando, 0);
      check("limpar_fim", Fim, 0);
      clear_and_load(4'd0, 4'd3, 4'd7);
      start();
      step(2);
      Reset = 1'b1;
      step(1);
      Reset = 1'b0;
      check("reset_mid_dig", digitos(), 12'h000);
      check("reset_mid_cont", Contando, 0);
      check("reset_mid_fim", Fim, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
